// File: rtl/uart_rx_fifo.sv
// UART receiver: 2-flop rx synchroniser, start-bit glitch rejection, optional parity,
// and a first-word-fall-through receive FIFO that stores per-entry framing/parity flags.

module uart_rx_fifo_chk #(
  parameter int DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   data_ready,
  input  logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;

  a_count_bound : assert property (@(posedge clock) disable iff (reset)
    count <= CW'(DEPTH));

  a_ready_matches_count : assert property (@(posedge clock) disable iff (reset)
    data_ready == (count != {CW{1'b0}}));

endmodule

module uart_rx_fifo #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int PARITY = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [15:0]            clock_divider,
  input  logic                   rx,
  input  logic                   read_en,
  input  logic                   clear_errors,
  output logic                   data_ready,
  output logic [WIDTH-1:0]       data_out,
  output logic                   frame_error,
  output logic                   parity_error,
  output logic                   overrun,
  output logic [$clog2(DEPTH):0] count
);

  localparam int   AW         = $clog2(DEPTH);
  localparam int   CW         = AW + 1;
  localparam int   EW         = WIDTH + 2;
  localparam int   BCW        = $clog2(WIDTH) + 1;
  localparam logic HAS_PARITY = (PARITY != 0);
  localparam logic ODD_PARITY = (PARITY == 2);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Expected parity bit for the received data word.
  function automatic logic parity_bit(input logic [WIDTH-1:0] data, input logic odd);
    parity_bit = (^data) ^ odd;
  endfunction

  state_t           state_r;
  state_t           state_nx_s;
  logic             rx_meta_r;
  logic             rx_sync_r;
  logic             rx_prev_r;
  logic [15:0]      div_q_r;
  logic [15:0]      cnt_r;
  logic [BCW-1:0]   bit_cnt_r;
  logic [WIDTH-1:0] shift_r;
  logic             perr_r;
  logic [EW-1:0]    mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             overrun_r;

  logic             fall_s;
  logic             mid_s;
  logic             wrap_s;
  logic             last_bit_s;
  logic             start_s;
  logic             shift_s;
  logic             par_s;
  logic             push_s;
  logic             busy_s;
  logic             pop_s;
  logic             full_s;
  logic             wr_en_s;
  logic             drop_s;
  logic [EW-1:0]    entry_s;
  logic [EW-1:0]    head_s;

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // cnt wraps every div_q cycles, so once aligned at the start-bit centre every
  // later mid-sample lands in the centre of the following bits.
  assign fall_s     = rx_prev_r & ~rx_sync_r;
  assign mid_s      = (cnt_r == (div_q_r >> 1));
  assign wrap_s     = (cnt_r == (div_q_r - 16'd1));
  assign last_bit_s = (bit_cnt_r == BCW'(WIDTH - 1));

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (fall_s) state_nx_s = ST_START;
        else        state_nx_s = ST_IDLE;
      end
      ST_START: begin
        if (mid_s) begin
          if (rx_sync_r) state_nx_s = ST_IDLE;
          else           state_nx_s = ST_DATA;
        end else begin
          state_nx_s = ST_START;
        end
      end
      ST_DATA: begin
        if (mid_s && last_bit_s) state_nx_s = HAS_PARITY ? ST_PARITY : ST_STOP;
        else                     state_nx_s = ST_DATA;
      end
      ST_PARITY: begin
        if (mid_s) state_nx_s = ST_STOP;
        else       state_nx_s = ST_PARITY;
      end
      ST_STOP: begin
        if (mid_s) state_nx_s = ST_IDLE;
        else       state_nx_s = ST_STOP;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // FSM output decode: per-state strobes for the datapath and FIFO.
  always_comb begin
    start_s = 1'b0;
    shift_s = 1'b0;
    par_s   = 1'b0;
    push_s  = 1'b0;
    busy_s  = 1'b1;
    case (state_r)
      ST_IDLE: begin
        busy_s  = 1'b0;
        start_s = fall_s;
      end
      ST_START:  busy_s  = 1'b1;
      ST_DATA:   shift_s = mid_s;
      ST_PARITY: par_s   = mid_s;
      ST_STOP:   push_s  = mid_s;
      default:   busy_s  = 1'b0;
    endcase
  end

  // Receive datapath: divider latch, bit timer, LSB-first shifter and parity check.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_q_r   <= 16'd0;
      cnt_r     <= 16'd0;
      bit_cnt_r <= {BCW{1'b0}};
      shift_r   <= {WIDTH{1'b0}};
      perr_r    <= 1'b0;
    end else if (start_s) begin
      div_q_r   <= clock_divider;
      cnt_r     <= 16'd0;
      bit_cnt_r <= {BCW{1'b0}};
      perr_r    <= 1'b0;
    end else if (busy_s) begin
      cnt_r <= wrap_s ? 16'd0 : (cnt_r + 16'd1);
      if (shift_s) begin
        shift_r   <= {rx_sync_r, shift_r[WIDTH-1:1]};
        bit_cnt_r <= bit_cnt_r + BCW'(1);
      end
      if (par_s) begin
        perr_r <= rx_sync_r ^ parity_bit(shift_r, ODD_PARITY);
      end
    end
  end

  // A frame completing into a full FIFO is accepted only if a pop frees a slot that edge.
  assign entry_s = {perr_r, ~rx_sync_r, shift_r};
  assign pop_s   = read_en & (count_r != {CW{1'b0}});
  assign full_s  = (count_r == CW'(DEPTH));
  assign wr_en_s = push_s & (~full_s | pop_s);
  assign drop_s  = push_s & full_s & ~pop_s;

  // FIFO storage; contents are only observed through the head while non-empty.
  always_ff @(posedge clock) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= entry_s;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally as DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (wr_en_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)   rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({wr_en_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky overrun; a new drop wins over a simultaneous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overrun_r <= 1'b0;
    end else if (drop_s) begin
      overrun_r <= 1'b1;
    end else if (clear_errors) begin
      overrun_r <= 1'b0;
    end else begin
      overrun_r <= overrun_r;
    end
  end

  assign head_s     = mem_r[rd_ptr_r];
  assign data_ready = (count_r != {CW{1'b0}});
  assign count      = count_r;
  assign overrun    = overrun_r;

  // Fall-through head view, forced to zero while empty.
  always_comb begin
    if (data_ready) begin
      {parity_error, frame_error, data_out} = head_s;
    end else begin
      {parity_error, frame_error, data_out} = {EW{1'b0}};
    end
  end

  uart_rx_fifo_chk #(
    .DEPTH (DEPTH)
  ) u_chk (
    .clock      (clock),
    .reset      (reset),
    .data_ready (data_ready),
    .count      (count)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: two instances (8N1 depth 4, 8E1 depth 8) checked every cycle
// against a frame-level FIFO model, plus hand-computed expectations for each scenario.
`timescale 1ns/1ps

module tb_uart_rx_fifo;

  localparam int W = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] clock_divider;
  logic [1:0]  rx_l;
  logic [1:0]  rd_l;
  logic [1:0]  clr_l;

  logic        rdy0, fe0, pe0, ov0;
  logic [7:0]  dout0;
  logic [2:0]  cnt0;
  logic        rdy1, fe1, pe1, ov1;
  logic [7:0]  dout1;
  logic [3:0]  cnt1;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  bit run_cmp  = 1'b0;

  // Frame-level model: one predicted completion per instance, FIFO as a ring of entries.
  bit         pend_v [2];
  int         pend_c [2];
  logic [9:0] pend_e [2];
  int         m_depth [2] = '{4, 8};
  int         m_size  [2];
  int         m_head  [2];
  bit         m_ovr   [2];
  logic [9:0] m_mem   [2][8];

  always #5 clock = ~clock;

  uart_rx_fifo #(.WIDTH(8), .DEPTH(4), .PARITY(0)) dut0 (
    .clock(clock), .reset(reset), .clock_divider(clock_divider), .rx(rx_l[0]),
    .read_en(rd_l[0]), .clear_errors(clr_l[0]), .data_ready(rdy0), .data_out(dout0),
    .frame_error(fe0), .parity_error(pe0), .overrun(ov0), .count(cnt0));

  uart_rx_fifo #(.WIDTH(8), .DEPTH(8), .PARITY(1)) dut1 (
    .clock(clock), .reset(reset), .clock_divider(clock_divider), .rx(rx_l[1]),
    .read_en(rd_l[1]), .clear_errors(clr_l[1]), .data_ready(rdy1), .data_out(dout1),
    .frame_error(fe1), .parity_error(pe1), .overrun(ov1), .count(cnt1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit f_pop(input int i);
    return rd_l[i] && (m_size[i] != 0);
  endfunction

  function automatic bit f_push(input int i);
    return pend_v[i] && (pend_c[i] == cyc);
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_size[i] <= 0;
        m_head[i] <= 0;
        m_ovr[i]  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (f_pop(i)) m_head[i] <= (m_head[i] + 1) % m_depth[i];
        if (f_push(i) && (m_size[i] < m_depth[i] || f_pop(i)))
          m_mem[i][(m_head[i] + m_size[i]) % m_depth[i]] <= pend_e[i];
        m_size[i] <= m_size[i]
                     + ((f_push(i) && (m_size[i] < m_depth[i] || f_pop(i))) ? 1 : 0)
                     - (f_pop(i) ? 1 : 0);
        if (f_push(i) && m_size[i] == m_depth[i] && !f_pop(i)) m_ovr[i] <= 1'b1;
        else if (clr_l[i])                                     m_ovr[i] <= 1'b0;
      end
    end
  end

  task automatic cmp_inst(input int i, input logic rdy, input logic [7:0] d, input logic fe,
                          input logic pe, input logic ov, input logic [3:0] c);
    logic [9:0] h;
    chk($sformatf("u%0d_data_ready", i), rdy, (m_size[i] != 0));
    chk($sformatf("u%0d_count", i), c, m_size[i]);
    chk($sformatf("u%0d_overrun", i), ov, m_ovr[i]);
    if (m_size[i] != 0) begin
      h = m_mem[i][m_head[i]];
      chk($sformatf("u%0d_data_out", i), d, h[7:0]);
      chk($sformatf("u%0d_frame_error", i), fe, h[8]);
      chk($sformatf("u%0d_parity_error", i), pe, h[9]);
    end
  endtask

  always @(negedge clock) begin
    if (run_cmp && !reset) begin
      cmp_inst(0, rdy0, dout0, fe0, pe0, ov0, {1'b0, cnt0});
      cmp_inst(1, rdy1, dout1, fe1, pe1, ov1, cnt1);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Driven just after posedge N, the stop bit is sampled on posedge
  // N + 4 + div/2 + (W+1+parity)*div: 2 sync flops, edge detect, then centre sampling.
  task automatic send_frame(input int i, input logic [7:0] d, input logic par_bit,
                            input logic stop_bit);
    int div;
    int nbits;
    logic [9:0] e;
    div   = int'(clock_divider);
    nbits = W + 1 + ((i == 1) ? 1 : 0);
    e     = {((i == 1) ? (par_bit != ^d) : 1'b0), ~stop_bit, d};
    pend_e[i] = e;
    pend_c[i] = cyc + 3 + div / 2 + nbits * div;
    pend_v[i] = 1'b1;
    rx_l[i] = 1'b0;
    tick(div);
    for (int b = 0; b < W; b++) begin
      rx_l[i] = d[b];
      tick(div);
    end
    if (i == 1) begin
      rx_l[i] = par_bit;
      tick(div);
    end
    rx_l[i] = stop_bit;
    tick(div);
    rx_l[i] = 1'b1;
  endtask

  task automatic read_one(input int i);
    rd_l[i] = 1'b1;
    tick(1);
    rd_l[i] = 1'b0;
  endtask

  task automatic wait_neg_cyc(input int target);
    int guard;
    guard = 0;
    @(negedge clock);
    while (cyc != target && guard < 20000) begin
      @(negedge clock);
      guard++;
    end
    chk("wait_target_cycle", cyc, target);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int tgt;
    reset = 1'b1;
    clock_divider = 16'd16;
    rx_l = 2'b11;
    rd_l = 2'b00;
    clr_l = 2'b00;
    pend_v[0] = 1'b0;
    pend_v[1] = 1'b0;
    tick(3);
    chk("rst_ready", rdy0, 1'b0);
    chk("rst_data", dout0, 8'h00);
    chk("rst_ferr", fe0, 1'b0);
    chk("rst_perr", pe0, 1'b0);
    chk("rst_ovr", ov0, 1'b0);
    chk("rst_count", cnt0, 3'd0);
    chk("rst_count_u1", cnt1, 4'd0);
    reset = 1'b0;
    run_cmp = 1'b1;
    tick(3);

    // 0x55 8N1 at div 16: ready appears exactly 156 edges after the start bit is driven.
    n0 = cyc;
    fork
      send_frame(0, 8'h55, 1'b0, 1'b1);
      begin
        wait_neg_cyc(n0 + 155);
        chk("t1_ready_before_push", rdy0, 1'b0);
        @(negedge clock);
        chk("t1_ready_after_push", rdy0, 1'b1);
        chk("t1_data", dout0, 8'h55);
        chk("t1_ferr", fe0, 1'b0);
        chk("t1_count", cnt0, 3'd1);
      end
    join
    read_one(0);
    chk("t1_ready_after_read", rdy0, 1'b0);
    chk("t1_count_after_read", cnt0, 3'd0);
    read_one(0);
    chk("t1_empty_read_ignored", cnt0, 3'd0);

    // Start-bit glitch of 5 cycles is rejected.
    rx_l[0] = 1'b0;
    tick(5);
    rx_l[0] = 1'b1;
    tick(40);
    chk("t2_glitch_count", cnt0, 3'd0);
    chk("t2_glitch_ready", rdy0, 1'b0);

    // Even parity: 0xA5 has four ones, so parity bit 1 is wrong and 0 is right.
    send_frame(1, 8'hA5, 1'b1, 1'b1);
    send_frame(1, 8'hA5, 1'b0, 1'b1);
    send_frame(1, 8'h07, 1'b1, 1'b1);
    tick(2);
    chk("t3_count", cnt1, 4'd3);
    chk("t3_data0", dout1, 8'hA5);
    chk("t3_perr0", pe1, 1'b1);
    read_one(1);
    chk("t3_data1", dout1, 8'hA5);
    chk("t3_perr1", pe1, 1'b0);
    read_one(1);
    chk("t3_data2", dout1, 8'h07);
    chk("t3_perr2", pe1, 1'b0);
    read_one(1);

    // Stop bit low: entry still pushed with frame_error.
    send_frame(0, 8'h3C, 1'b0, 1'b0);
    tick(4);
    chk("t4_ferr", fe0, 1'b1);
    chk("t4_data", dout0, 8'h3C);
    read_one(0);

    // Overrun at depth 4.
    for (int k = 1; k <= 5; k++) send_frame(0, 8'(k), 1'b0, 1'b1);
    tick(2);
    chk("t5_count_full", cnt0, 3'd4);
    chk("t5_overrun_set", ov0, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      chk("t5_read_order", dout0, 8'(k));
      read_one(0);
    end
    chk("t5_drained", rdy0, 1'b0);
    clr_l[0] = 1'b1;
    tick(1);
    clr_l[0] = 1'b0;
    chk("t5_overrun_cleared", ov0, 1'b0);

    // Full FIFO with a pop on the same edge as the fifth push: no overrun.
    for (int k = 0; k < 4; k++) send_frame(0, 8'h0A + 8'(k), 1'b0, 1'b1);
    tgt = cyc + 3 + 8 + 9 * 16;
    fork
      send_frame(0, 8'h0E, 1'b0, 1'b1);
      begin
        while (cyc < tgt) tick(1);
        rd_l[0] = 1'b1;
        tick(1);
        rd_l[0] = 1'b0;
      end
    join
    tick(2);
    chk("t5b_count", cnt0, 3'd4);
    chk("t5b_overrun", ov0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk("t5b_read_order", dout0, 8'h0B + 8'(k));
      read_one(0);
    end

    // Divider change mid-frame applies only to the next frame (odd divider 7).
    fork
      send_frame(0, 8'hC3, 1'b0, 1'b1);
      begin
        tick(20);
        clock_divider = 16'd7;
      end
    join
    send_frame(0, 8'h5A, 1'b0, 1'b1);
    tick(4);
    chk("t6_div_data0", dout0, 8'hC3);
    read_one(0);
    chk("t6_div_data1", dout0, 8'h5A);
    read_one(0);
    clock_divider = 16'd16;

    // Reset in the middle of a frame, with one entry already held.
    send_frame(0, 8'h99, 1'b0, 1'b1);
    tick(2);
    chk("t7_pre_reset_count", cnt0, 3'd1);
    rx_l[0] = 1'b0;
    tick(40);
    reset = 1'b1;
    rx_l[0] = 1'b1;
    #1;
    chk("t7_rst_ready", rdy0, 1'b0);
    chk("t7_rst_data", dout0, 8'h00);
    chk("t7_rst_ferr", fe0, 1'b0);
    chk("t7_rst_count", cnt0, 3'd0);
    tick(2);
    reset = 1'b0;
    tick(5);
    send_frame(0, 8'h7E, 1'b0, 1'b1);
    send_frame(0, 8'h11, 1'b0, 1'b1);
    send_frame(0, 8'h22, 1'b0, 1'b1);
    tick(2);
    chk("t7_count", cnt0, 3'd3);
    chk("t7_data_7e", dout0, 8'h7E);
    read_one(0);
    chk("t7_data_11", dout0, 8'h11);
    read_one(0);
    chk("t7_data_22", dout0, 8'h22);
    read_one(0);
    chk("t7_empty", rdy0, 1'b0);

    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
